// File: rtl/qddc.sv
// qddc: quadrature digital down-converter, 14-bit ADC I/Q -> CIC R=4 -> NCO mixer -> CIC R=32 -> 16-bit baseband at clk/128
// Ports: clk; reset (sync, active-high); in_i/in_q signed 14-bit ADC samples every clk;
//        lo_freq/lo_dir/lo_ns_en NCO controls; iq_swap swaps I/Q at the input register;
//        tuner_byp bypasses the mixer (tuner held in reset); out_i/out_q signed 16-bit baseband,
//        held between strobes; out_valid 1-clk strobe every 128 clks.

// qddc_cic: 3-stage CIC decimator slice; integrators advance on ien, combs on cen, dout = top 16 bits of last comb
module qddc_cic #(
    parameter int IW = 14,
    parameter int W  = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ien,
    input  logic          cen,
    input  logic [IW-1:0] din,
    output logic [15:0]   dout
);
    logic [W-1:0] i1, i2, i3, d1, d2, d3, c1, c2, c3, y;
    // comb chain is combinational so the decimated output is not delayed by extra comb pipeline stages
    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;
    assign dout = y[W-1 -: 16];
    always_ff @(posedge clk) begin
        if (reset) begin
            {i1, i2, i3, d1, d2, d3, y} <= '0;
        end else begin
            if (ien) begin
                i1 <= i1 + W'($signed(din));
                i2 <= i2 + i1;
                i3 <= i3 + i2;
            end
            if (cen) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                y  <= c3;
            end
        end
    end
endmodule

// ci_co_tuner: 8-phase NCO complex mixer; dir=0 multiplies by exp(-j*phase), dir=1 by exp(+j*phase)
module ci_co_tuner (
    input  logic        clk,
    input  logic        reset,
    input  logic [30:0] freq,
    input  logic        dir,
    input  logic        ns_en,
    input  logic [15:0] in_i,
    input  logic [15:0] in_q,
    output logic [15:0] out_i,
    output logic [15:0] out_q
);
    logic [30:0] ph, mi, mq;
    logic [15:0] lfsr;
    logic [2:0] k;
    logic signed [16:0] c, s;
    function automatic logic signed [16:0] cosv(input logic [2:0] a);
        logic signed [16:0] m;
        m = (a[1:0] == 2'd0) ? 17'sd32767 : (a[0] ? 17'sd23170 : 17'sd0);
        return (a >= 3'd3 && a <= 3'd5) ? -m : m;
    endfunction
    // LFSR dither on the phase below the octant boundary spreads the phase-truncation spurs
    assign k = 3'((ph + (ns_en ? {3'b0, lfsr, 12'b0} : 31'd0)) >> 28);
    assign c = cosv(k);
    assign s = dir ? -cosv(k + 3'd6) : cosv(k + 3'd6);
    // only bits [30:15] are kept, so modular 31-bit products are exact there
    assign mi = 31'($signed(in_i)) * 31'(c) + 31'($signed(in_q)) * 31'(s);
    assign mq = 31'($signed(in_q)) * 31'(c) - 31'($signed(in_i)) * 31'(s);
    always_ff @(posedge clk) begin
        if (reset) begin
            ph    <= '0;
            lfsr  <= 16'hace1;
            out_i <= '0;
            out_q <= '0;
        end else begin
            ph    <= ph + freq;
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_i <= 16'(mi >> 15);
            out_q <= 16'(mq >> 15);
        end
    end
endmodule

module qddc #(
    localparam int ISZ = 14,
    localparam int FSZ = 31,
    localparam int OSZ = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [ISZ-1:0] in_i,
    input  logic [ISZ-1:0] in_q,
    input  logic [FSZ-1:0] lo_freq,
    input  logic           lo_dir,
    input  logic           lo_ns_en,
    input  logic           iq_swap,
    input  logic           tuner_byp,
    output logic [OSZ-1:0] out_i,
    output logic [OSZ-1:0] out_q,
    output logic           out_valid
);
    logic [6:0] div;
    logic s1, s2;
    logic [ISZ-1:0] x_i, x_q;
    logic [OSZ-1:0] c1_i, c1_q, t_i, t_q, c2_i, c2_q;
    assign s1 = &div[1:0];
    assign s2 = &div;
    always_ff @(posedge clk) begin
        if (reset) begin
            {div, x_i, x_q, c2_i, c2_q, out_valid} <= '0;
        end else begin
            div       <= div + 7'd1;
            x_i       <= iq_swap ? in_q : in_i;
            x_q       <= iq_swap ? in_i : in_q;
            c2_i      <= tuner_byp ? c1_i : t_i;
            c2_q      <= tuner_byp ? c1_q : t_q;
            out_valid <= s2;
        end
    end
    qddc_cic #(.IW(ISZ), .W(20)) u_c1i (.clk, .reset, .ien(1'b1), .cen(s1), .din(x_i), .dout(c1_i));
    qddc_cic #(.IW(ISZ), .W(20)) u_c1q (.clk, .reset, .ien(1'b1), .cen(s1), .din(x_q), .dout(c1_q));
    ci_co_tuner u_tuner (
        .clk, .reset(reset | tuner_byp), .freq(lo_freq), .dir(lo_dir), .ns_en(lo_ns_en),
        .in_i(c1_i), .in_q(c1_q), .out_i(t_i), .out_q(t_q)
    );
    // the second CIC's last-comb register is the output register itself: it loads on the s2 edge
    qddc_cic #(.IW(OSZ), .W(31)) u_c2i (.clk, .reset, .ien(s1), .cen(s2), .din(c2_i), .dout(out_i));
    qddc_cic #(.IW(OSZ), .W(31)) u_c2q (.clk, .reset, .ien(s1), .cen(s2), .din(c2_q), .dout(out_q));
endmodule
